// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared types and default widths for the ALU responder pipeline.
//   alu_sel_e   : opcode encoding carried on in_sel / out_sel.
//   stage_t     : reference view of one pipeline slot at the default width.
//   DefaultDwidth / DefaultCntw : default operand and counter widths.
package alu_pipe_pkg;

    localparam int unsigned DefaultDwidth = 32;
    localparam int unsigned DefaultCntw   = 16;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic                     valid;
        alu_sel_e                 sel;
        logic [DefaultDwidth-1:0] op1;
        logic [DefaultDwidth-1:0] op2;
        logic [DefaultDwidth-1:0] res;
    } stage_t;

endpackage

// File: rtl/alu_pipe_stage.sv
// alu_pipe_stage: generic valid/ready register slice that holds its contents on stall.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid / in_ready / in_data    : upstream side; in_ready means this slice advances
//   out_valid / out_ready / out_data : downstream side
module alu_pipe_stage #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             valid_q;
    logic [Width-1:0] data_q;

    // The slice advances when empty or when its contents move on this edge.
    always_comb begin
        in_ready  = !valid_q || out_ready;
        out_valid = valid_q;
        out_data  = data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            // Payload only loads with a real transaction; idle inputs are ignored.
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_resp.sv
// alu_pipe_resp: responder for the ALU stimulus interface. Transactions pass through three
// slices: S1 (operands), S2 (result), S3 (output register). A counter tracks completed
// output handshakes.
// Macro ALU_FLAGS_EN adds registered out_zero / out_carry outputs.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid, in_ready, in_sel, in_op1, in_op2 : request side
//   out_valid, out_ready, out_res, out_sel      : response side
//   done_cnt                                    : completed handshakes, wraps
//   out_zero, out_carry                         : only with ALU_FLAGS_EN
module alu_pipe_resp
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DWIDTH = DefaultDwidth,
    parameter int unsigned CNTW   = DefaultCntw
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [DWIDTH-1:0] in_op1,
    input  logic [DWIDTH-1:0] in_op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_res,
    output logic [1:0]        out_sel,
    output logic [CNTW-1:0]   done_cnt
`ifdef ALU_FLAGS_EN
    ,
    output logic              out_zero,
    output logic              out_carry
`endif
);

    localparam int unsigned S1W = 2 + 2 * DWIDTH;
`ifdef ALU_FLAGS_EN
    localparam int unsigned S2W = 2 + DWIDTH + 1;
    localparam int unsigned S3W = 2 + DWIDTH + 2;
`else
    localparam int unsigned S2W = 2 + DWIDTH;
    localparam int unsigned S3W = 2 + DWIDTH;
`endif

    logic             s1_ready, s1_valid;
    logic             s2_ready, s2_valid;
    logic             s3_ready;
    logic [S1W-1:0]   s1_data;
    logic [S2W-1:0]   s2_in, s2_data;
    logic [S3W-1:0]   s3_in, s3_data;

    logic [1:0]        s1_sel;
    logic [DWIDTH-1:0] s1_op1, s1_op2, alu_res;
    logic [1:0]        s2_sel;
    logic [DWIDTH-1:0] s2_res;
    logic [CNTW-1:0]   done_cnt_q;

    alu_pipe_stage #(.Width(S1W)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s1_ready),
        .in_data   ({in_sel, in_op1, in_op2}),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_data)
    );

    assign s1_sel = s1_data[S1W-1 -: 2];
    assign s1_op1 = s1_data[S1W-3 -: DWIDTH];
    assign s1_op2 = s1_data[DWIDTH-1:0];

    // Result is modulo 2^DWIDTH; SUB wraps in two's complement.
    always_comb begin
        alu_res = '0;
        unique case (alu_sel_e'(s1_sel))
            ADD: alu_res = s1_op1 + s1_op2;
            SUB: alu_res = s1_op1 - s1_op2;
            AND: alu_res = s1_op1 & s1_op2;
            OR:  alu_res = s1_op1 | s1_op2;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic alu_carry;
    logic s2_carry;

    // ADD carries out iff the truncated sum wrapped below op1; SUB reports NOT-borrow.
    always_comb begin
        alu_carry = 1'b0;
        unique case (alu_sel_e'(s1_sel))
            ADD:     alu_carry = (alu_res < s1_op1);
            SUB:     alu_carry = (s1_op1 >= s1_op2);
            default: alu_carry = 1'b0;
        endcase
    end

    assign s2_in    = {s1_sel, alu_res, alu_carry};
    assign s2_sel   = s2_data[S2W-1 -: 2];
    assign s2_res   = s2_data[S2W-3 -: DWIDTH];
    assign s2_carry = s2_data[0];
    assign s3_in    = {s2_sel, s2_res, s2_carry, (s2_res == '0)};
    assign out_carry = s3_data[1];
    assign out_zero  = s3_data[0];
`else
    assign s2_in  = {s1_sel, alu_res};
    assign s2_sel = s2_data[S2W-1 -: 2];
    assign s2_res = s2_data[DWIDTH-1:0];
    assign s3_in  = {s2_sel, s2_res};
`endif

    alu_pipe_stage #(.Width(S2W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_ready (s3_ready),
        .out_data  (s2_data)
    );

    alu_pipe_stage #(.Width(S3W)) u_s3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s2_valid),
        .in_ready  (s3_ready),
        .in_data   (s3_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s3_data)
    );

    assign out_sel = s3_data[S3W-1 -: 2];
    assign out_res = s3_data[S3W-3 -: DWIDTH];

    // Combinational through the stall chain; held low while reset is asserted.
    assign in_ready = reset && s1_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            done_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt_q <= done_cnt_q + CNTW'(1);
        end
    end

    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_alu_pipe_resp.sv
module tb_alu_pipe_resp;
    import alu_pipe_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [1:0]    in_sel = 2'b00;
    logic [DW-1:0] in_op1 = '0;
    logic [DW-1:0] in_op2 = '0;

    logic          in_ready, out_valid, in_ready4, out_valid4;
    logic [DW-1:0] out_res, out_res4;
    logic [1:0]    out_sel, out_sel4;
    logic [15:0]   done_cnt;
    logic [3:0]    done_cnt4;
`ifdef ALU_FLAGS_EN
    logic out_zero, out_carry, out_zero4, out_carry4;
`endif

    alu_pipe_resp #(.DWIDTH(DW), .CNTW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sel   (out_sel),
        .done_cnt  (done_cnt)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_carry (out_carry)
`endif
    );

    // Narrow-counter instance to exercise done_cnt wrap.
    alu_pipe_resp #(.DWIDTH(DW), .CNTW(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .in_sel    (in_sel),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_res   (out_res4),
        .out_sel   (out_sel4),
        .done_cnt  (done_cnt4)
`ifdef ALU_FLAGS_EN
        ,
        .out_zero  (out_zero4),
        .out_carry (out_carry4)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    stage_t      exp_q[$];
    int unsigned model_cnt = 0;
    int          ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_res(input logic [1:0] s, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic model_carry(input stage_t e);
        longint unsigned s;
        case (e.sel)
            ADD: begin
                s = longint'(e.op1) + longint'(e.op2);
                return s > 64'h0000_0000_FFFF_FFFF;
            end
            SUB:     return e.op1 >= e.op2;
            default: return 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            default: return $urandom;
        endcase
    endfunction

    task automatic push(input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        stage_t e;
        e.valid = 1'b1;
        e.sel   = alu_sel_e'(s);
        e.op1   = a;
        e.op2   = b;
        e.res   = model_res(s, a, b);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_sel   = s;
        in_op1   = a;
        in_op2   = b;
    endtask

    // Junk on the data inputs while idle must never reach the pipeline.
    task automatic idle();
        in_valid = 1'b0;
        in_sel   = 2'($urandom);
        in_op1   = $urandom;
        in_op2   = $urandom;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit ok;
        ok = 1'b0;
        drive(s, a, b);
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                check("in_ready4_at_accept", in_ready4, 1);
                push(s, a, b);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 64 cycles, expected 1");
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        #1;
    endtask

    // out_ready is owned by this process only.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stall hold.
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_res;
    logic [1:0]    prev_sel;

    always @(negedge clk) begin : mon
        stage_t e;
        if (!reset) begin
            exp_q.delete();
            model_cnt  = 0;
            stall_prev = 1'b0;
        end else begin
            check("done_cnt", done_cnt, model_cnt[15:0]);
            check("done_cnt4", done_cnt4, model_cnt[3:0]);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_res", out_res, prev_res);
                check("stall_sel", out_sel, prev_sel);
            end
            if (out_valid || out_valid4) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got out_res=0x%0h, expected no output", out_res);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("out_valid", out_valid, 1);
                    check("out_valid4", out_valid4, 1);
                    check("out_res", out_res, e.res);
                    check("out_sel", out_sel, e.sel);
                    check("out_res4", out_res4, e.res);
                    check("out_sel4", out_sel4, e.sel);
`ifdef ALU_FLAGS_EN
                    check("out_zero", out_zero, e.res == '0);
                    check("out_carry", out_carry, model_carry(e));
                    check("out_zero4", out_zero4, e.res == '0);
                    check("out_carry4", out_carry4, model_carry(e));
`endif
                    model_cnt++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_res   = out_res;
            prev_sel   = out_sel;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, expected completion");
        $fatal(1, "watchdog");
    end

    logic [1:0]    bp_sel[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [DW-1:0] bp_a[4]   = '{32'd100, 32'd7, 32'hFF00, 32'h0F0F};
    logic [DW-1:0] bp_b[4]   = '{32'd23, 32'd9, 32'h0FF0, 32'hF000};

    initial begin
        int idx;

        // Reset held for 3 cycles with a transaction offered.
        drive(2'b00, 32'd1, 32'd2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_in_ready4", in_ready4, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_sel", out_sel, 0);
        @(posedge clk);
        #1;
        idle();
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // ADD latency: visible after the second edge past acceptance.
        send(ADD, 32'd5, 32'd3);
        idle();
        @(negedge clk);
        check("lat_k0_valid", out_valid, 0);
        @(negedge clk);
        check("lat_k1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_k2_valid", out_valid, 1);
        check("lat_k2_res", out_res, 32'd8);
        check("lat_k2_sel", out_sel, 2'b00);
        @(negedge clk);
        check("lat_done_cnt", done_cnt, 1);
        @(posedge clk);
        #1;

        // SUB wrap.
        send(SUB, 32'd4, 32'd10);
        idle();
        repeat (3) @(negedge clk);
        check("sub_valid", out_valid, 1);
        check("sub_res", out_res, 32'hFFFF_FFFA);
`ifdef ALU_FLAGS_EN
        check("sub_carry", out_carry, 0);
        check("sub_zero", out_zero, 0);
`endif
        @(posedge clk);
        #1;

        // Back-to-back: three results on consecutive cycles.
        send(SUB, 32'd10, 32'd4);
        send(AND, 32'hF0F0, 32'h0FF0);
        send(OR, 32'hF000, 32'h000F);
        idle();
        @(negedge clk);
        check("b2b0_valid", out_valid, 1);
        check("b2b0_res", out_res, 32'd6);
        @(negedge clk);
        check("b2b1_valid", out_valid, 1);
        check("b2b1_res", out_res, 32'h00F0);
        @(negedge clk);
        check("b2b2_valid", out_valid, 1);
        check("b2b2_res", out_res, 32'hF00F);
        @(posedge clk);
        #1;

        // Backpressure: three accepts fill the pipe, the fourth waits.
        ready_mode = 0;
        @(posedge clk);
        #1;
        idx = 0;
        drive(bp_sel[0], bp_a[0], bp_b[0]);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_ready && idx < 4) begin
                push(bp_sel[idx], bp_a[idx], bp_b[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 4) drive(bp_sel[idx], bp_a[idx], bp_b[idx]);
            else idle();
        end
        check("bp_accepts", idx, 3);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        ready_mode = 1;
        @(negedge clk);
        // Full pipe with out_ready high drains and accepts on the same edge.
        check("bp_drain_accept", in_ready, 1);
        if (in_ready) begin
            push(bp_sel[3], bp_a[3], bp_b[3]);
        end
        @(posedge clk);
        #1;
        idle();
        drain();

        // Randomized traffic with random backpressure and idle gaps.
        ready_mode = 2;
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            send(2'($urandom), rand_op(), rand_op());
        end
        idle();
        ready_mode = 1;
        drain();

        // Mid-flight reset discards in-flight work.
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(ADD, 32'd1, 32'd1);
        send(OR, 32'd2, 32'd4);
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        ready_mode = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mf_no_out", out_valid, 0);
        end
        @(posedge clk);
        #1;

        // 17 completions: the 4-bit counter wraps to 1.
        for (int t = 0; t < 17; t++) begin
            send(2'($urandom), rand_op(), rand_op());
        end
        idle();
        drain();
        @(negedge clk);
        check("wrap_cnt4", done_cnt4, 1);
        check("wrap_cnt16", done_cnt, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe_resp.md
Name: alu_pipe_resp

Overview:
- Responder end of the ALU stimulus interface: accepts operand/opcode transactions from a driver and returns results through a 3-stage valid/ready pipeline.
- Sits in the core beside the register and two-stage-pipeline blocks and is reachable by the bench probes.
- Carries a completed-transaction counter for bench cross-checking.

Parameters:
- DWIDTH, 32, operand and result width.
- CNTW, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  driver presents a transaction.
- in_ready  out  1  block can accept this cycle.
- in_sel  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
- in_op1  in  DWIDTH  operand 1.
- in_op2  in  DWIDTH  operand 2.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  DWIDTH  result.
- out_sel  out  2  opcode that produced out_res (echo).
- done_cnt  out  CNTW  count of completed output handshakes.

Behaviour:
- Reset: clk edge with reset==0 clears all stage valids, out_res, out_sel and done_cnt to 0, and forces in_ready=0. Pipeline contents are discarded mid-flight, with no partial output. in_ready returns to 1 in the first cycle after reset deasserts.
- Stages:
  - S1 registers op1/op2/sel.
  - S2 computes the result.
  - S3 is the output register driving out_*.
- Stage i advances when S(i+1) is empty or S(i+1) advances. S3 advances when out_valid==0 or out_ready==1.
- in_ready = !S1.valid || S1 advances. This is combinational from out_ready through the stall chain and has no register.
- Accept: in_valid && in_ready at edge k places the transaction in S1. out_valid rises after edge k+2, provided no stall.
- Throughput: 1 transaction per cycle when out_ready is held high.
- Stall hold: while out_valid && !out_ready, out_res and out_sel stay stable. Upstream stages fill and then hold; no transaction is dropped or duplicated.
- Ordering: results leave strictly in acceptance order.
- Arithmetic: modulo 2^DWIDTH. Carry and borrow are discarded. SUB is op1 - op2, two's complement.
- Input values while in_valid==0 are ignored and never enter the pipeline.
- done_cnt increments on every out_valid && out_ready edge and wraps from 2^CNTW-1 to 0.
- Simultaneous events:
  - A full pipeline plus out_ready=1 plus in_valid=1 gives a drain and an accept on the same edge, with no bubble.
  - reset==0 overrides every handshake in the same cycle.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined:
  - Adds outputs out_zero (1 bit: out_res == 0) and out_carry (1 bit: carry-out of ADD, or NOT-borrow of SUB; 0 for AND/OR).
  - Both are registered with S3, held under stall, and reset to 0.
- Undefined: the ports are absent, and the carry logic and its S3 storage are not synthesized.

Decomposition:
- Package alu_pipe_pkg holds:
  - the alu_sel_e enum (ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11);
  - a stage struct {valid, sel, op1, op2, res};
  - default width constants.
- Sub-module alu_pipe_stage: a generic valid/ready register slice with hold-on-stall, instantiated 3 times. Compute logic sits between S1 and S2.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles → out_valid=0, done_cnt=0, in_ready=0. Release → in_ready=1 in the next cycle.
- ADD latency: accept sel=00, op1=5, op2=3 at edge k with out_ready=1 → out_valid=1 and out_res=8, out_sel=00 after edge k+2. done_cnt=1 after the handshake.
- SUB wrap: sel=01, op1=4, op2=10 → out_res=32'hFFFFFFFA. With ALU_FLAGS_EN: out_carry=0, out_zero=0.
- Back-to-back: stream 10/4 SUB, 0xF0F0/0x0FF0 AND, 0xF000/0x000F OR on consecutive cycles with out_ready=1 → 6, 0x00F0, 0xF00F on consecutive cycles, no bubbles.
- Backpressure: hold out_ready=0 and offer 4 transactions → in_ready drops after exactly 3 accepts and out_res stays stable. Release → all 3 results emerge in order, then the 4th is accepted.
- Mid-flight reset plus counter wrap:
  - Assert reset=0 with 2 transactions in flight → both are discarded and no out_valid appears afterwards.
  - Separately, with CNTW=4, complete 17 transactions → done_cnt=1.
